// File: rtl/ro_ctrl_pkg.sv
// Shared definitions for the ring-oscillator sweep controller.
//   - state_t  : sweep FSM states
//   - NUM_SEL / NUM_CH / CH_W / SEL_IDX_W : array geometry and index widths
//   - PT_W     : width of a linear (sel,ch) point index, including one past the end
//   - result_t : one measurement result {count, sel, ch, ovf}
package ro_ctrl_pkg;

  localparam int NUM_SEL   = 5;
  localparam int NUM_CH    = 16;
  localparam int CH_W      = 4;
  localparam int SEL_IDX_W = 3;
  localparam int CNT_W_MAX = 16;
  localparam int PT_W      = $clog2(NUM_SEL * NUM_CH + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SETTLE,
    ST_GATE,
    ST_REPORT,
    ST_ADVANCE,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [CNT_W_MAX-1:0] count;
    logic [SEL_IDX_W-1:0] sel;
    logic [CH_W-1:0]      ch;
    logic                 ovf;
  } result_t;

endpackage

// File: rtl/ro_edge_counter.sv
// Synchronises the asynchronous oscillator output, detects its rising edges
// and counts them with saturation.
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   clr   : clear count and overflow flag
//   en    : count detected edges while high
//   ro    : asynchronous oscillator / mux output
//   count : saturating edge count
//   ovf   : set once count reaches its maximum
module ro_edge_counter
  import ro_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             ro,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // sync_reg[0..1] is the two-flop synchroniser, sync_reg[2] the edge-detect flop
  logic [2:0]       sync_reg;
  logic [CNT_W-1:0] count_reg;
  logic             ovf_reg;
  logic             rise;

  assign rise = sync_reg[1] & ~sync_reg[2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_reg  <= '0;
      count_reg <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[1:0], ro};
      if (clr) begin
        count_reg <= '0;
        ovf_reg   <= 1'b0;
      end else if (en && rise && (count_reg != CNT_MAX)) begin
        count_reg <= count_reg + 1'b1;
        // flag as soon as the counter lands on its ceiling: any further
        // edges are lost, so the value can no longer be trusted as exact
        if (count_reg == CNT_MAX - 1'b1) begin
          ovf_reg <= 1'b1;
        end
      end
    end
  end

  assign count = count_reg;
  assign ovf   = ovf_reg;

endmodule

// File: rtl/ro_sweep_ctrl.sv
// Sweep sequencer for the ring-oscillator characterisation array.
// Walks every enabled (stage select, mux channel) point, sel outer / ch inner:
// SETUP -> SETTLE (start high, not counting) -> GATE (start high, counting)
// -> REPORT (valid/ready handshake) -> ADVANCE to the next enabled point.
//   wb_clk_i, wb_rst_n_i      : clock, synchronous active-low reset
//   go_i, abort_i             : start a sweep / force back to idle
//   ch_mask_i, sel_mask_i     : points to measure, captured on go_i
//   ro_i                      : asynchronous oscillator mux output
//   s_o, start_o, mux_sel_o   : oscillator stage select, enable, mux select
//   busy_o, done_o            : sweep in progress / sweep finished pulse
//   res_valid_o, res_ready_i  : result handshake
//   res_count_o, res_sel_o, res_ch_o, res_ovf_o : result payload
module ro_sweep_ctrl
  import ro_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int GATE_CYCLES   = 1024,
  parameter int CNT_W         = 16
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_n_i,
  input  logic                 go_i,
  input  logic                 abort_i,
  input  logic [NUM_CH-1:0]    ch_mask_i,
  input  logic [NUM_SEL-1:0]   sel_mask_i,
  input  logic                 ro_i,
  output logic [NUM_SEL-1:0]   s_o,
  output logic                 start_o,
  output logic [CH_W-1:0]      mux_sel_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [CNT_W-1:0]     res_count_o,
  output logic [SEL_IDX_W-1:0] res_sel_o,
  output logic [CH_W-1:0]      res_ch_o,
  output logic                 res_ovf_o
);

  localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);

  state_t               state_reg, state_next;
  logic [NUM_SEL-1:0]   sel_mask_reg, sel_mask_next;
  logic [NUM_CH-1:0]    ch_mask_reg, ch_mask_next;
  logic [SEL_IDX_W-1:0] cur_sel_reg, cur_sel_next;
  logic [CH_W-1:0]      cur_ch_reg, cur_ch_next;
  logic [PT_W-1:0]      scan_reg, scan_next;   // first linear point eligible for the next search
  logic [TMR_W-1:0]     timer_reg, timer_next;

  logic                 hit_found;
  logic [SEL_IDX_W-1:0] hit_sel;
  logic [CH_W-1:0]      hit_ch;

  // Priority search for the first enabled point at or after scan_reg.
  // Scanning downward lets the lowest matching index win the last assignment.
  always_comb begin
    hit_found = 1'b0;
    hit_sel   = '0;
    hit_ch    = '0;
    for (int s = NUM_SEL - 1; s >= 0; s--) begin
      for (int c = NUM_CH - 1; c >= 0; c--) begin
        if (sel_mask_reg[SEL_IDX_W'(s)] && ch_mask_reg[CH_W'(c)] &&
            ((s * NUM_CH + c) >= int'(scan_reg))) begin
          hit_found = 1'b1;
          hit_sel   = SEL_IDX_W'(s);
          hit_ch    = CH_W'(c);
        end
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    sel_mask_next = sel_mask_reg;
    ch_mask_next  = ch_mask_reg;
    cur_sel_next  = cur_sel_reg;
    cur_ch_next   = cur_ch_reg;
    scan_next     = scan_reg;
    timer_next    = timer_reg;
    case (state_reg)
      ST_IDLE: begin
        if (go_i && !abort_i) begin
          sel_mask_next = sel_mask_i;
          ch_mask_next  = ch_mask_i;
          scan_next     = '0;
          state_next    = ST_ADVANCE;
        end
      end
      ST_ADVANCE: begin
        if (hit_found) begin
          cur_sel_next = hit_sel;
          cur_ch_next  = hit_ch;
          state_next   = ST_SETUP;
        end else begin
          state_next = ST_DONE;
        end
      end
      ST_SETUP: begin
        timer_next = '0;
        state_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (timer_reg == SETTLE_LAST) begin
          timer_next = '0;
          state_next = ST_GATE;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      ST_GATE: begin
        if (timer_reg == GATE_LAST) begin
          state_next = ST_REPORT;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      ST_REPORT: begin
        if (res_ready_i) begin
          // NUM_CH is a power of two, so {sel,ch} is the linear point index
          scan_next  = PT_W'({cur_sel_reg, cur_ch_reg}) + PT_W'(1);
          state_next = ST_ADVANCE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    if (abort_i && (state_reg != ST_IDLE)) begin
      state_next = ST_IDLE;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_reg    <= ST_IDLE;
      sel_mask_reg <= '0;
      ch_mask_reg  <= '0;
      cur_sel_reg  <= '0;
      cur_ch_reg   <= '0;
      scan_reg     <= '0;
      timer_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      sel_mask_reg <= sel_mask_next;
      ch_mask_reg  <= ch_mask_next;
      cur_sel_reg  <= cur_sel_next;
      cur_ch_reg   <= cur_ch_next;
      scan_reg     <= scan_next;
      timer_reg    <= timer_next;
    end
  end

  // The counter is frozen outside GATE and cleared only in SETUP, so it
  // doubles as the result hold register for the whole REPORT phase.
  ro_edge_counter #(
    .CNT_W (CNT_W)
  ) u_edge_counter (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_n_i),
    .clr   (state_reg == ST_SETUP),
    .en    (state_reg == ST_GATE),
    .ro    (ro_i),
    .count (res_count_o),
    .ovf   (res_ovf_o)
  );

  logic point_active;

  always_comb begin
    point_active = (state_reg == ST_SETUP) || (state_reg == ST_SETTLE) ||
                   (state_reg == ST_GATE)  || (state_reg == ST_REPORT);
    s_o          = '0;
    mux_sel_o    = '0;
    if (point_active) begin
      // cur_sel_reg never exceeds NUM_SEL-1, so this is always one-hot
      s_o       = NUM_SEL'(1) << cur_sel_reg;
      mux_sel_o = cur_ch_reg;
    end
    start_o     = (state_reg == ST_SETTLE) || (state_reg == ST_GATE);
    busy_o      = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
    done_o      = (state_reg == ST_DONE);
    res_valid_o = (state_reg == ST_REPORT);
    res_sel_o   = cur_sel_reg;
    res_ch_o    = cur_ch_reg;
  end

endmodule
